// File: rtl/ad80305_pkg.sv
// ad80305_pkg: shared state encodings and default parameters for the AD80305 RX link controller
package ad80305_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      WAIT_FILL = 3'd2,
      CHECK     = 3'd3,
      LOCKED    = 3'd4,
      FAULT     = 3'd5
   } state_t;
   localparam int DEF_RST_CYCLES   = 16;
   localparam int DEF_FILL_TIMEOUT = 64;
   localparam int DEF_FP_PERIOD    = 4;
   localparam int DEF_LOCK_STROBES = 32;
   localparam int DEF_ERR_CNT_W    = 8;
endpackage

// File: rtl/ad80305_fp_checker.sv
// ad80305_fp_checker: iqdata_fp cadence checker (gap counter, good/early/missing classification)
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear; masks all outputs and disarms the checker
//   fp       : sample strobe
//   good     : strobe arrived with gap == FP_PERIOD-1
//   err      : early strobe, or gap reached FP_PERIOD without a strobe
//   first    : first strobe after clear (only arms the checker, never judged)
module ad80305_fp_checker #(
   parameter int FP_PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic fp,
   output logic good,
   output logic err,
   output logic first
);
   localparam int GW = $clog2(FP_PERIOD + 1);
   localparam logic [GW-1:0] LAST = GW'(FP_PERIOD - 1);
   localparam logic [GW-1:0] MAXG = GW'(FP_PERIOD);
   logic [GW-1:0] gap;
   logic armed;
   assign first = ~clr & fp & ~armed;
   assign good  = ~clr & fp & armed & (gap == LAST);
   // a strobe landing once gap has hit FP_PERIOD is still an error (already missing)
   assign err   = ~clr & armed & ((gap == MAXG) | (fp & (gap < LAST)));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gap   <= '0;
         armed <= 1'b0;
      end else if (clr) begin
         gap   <= '0;
         armed <= 1'b0;
      end else if (fp) begin
         gap   <= '0;
         armed <= 1'b1;
      end else if (armed && gap != MAXG) begin
         gap   <= gap + GW'(1);
      end
endmodule

// File: rtl/ad80305_rx_link_ctrl.sv
// ad80305_rx_link_ctrl: bring-up and supervision FSM for the AD80305 DDR/LVDS receive link
//   i_fpga_clk_125p, i_fpga_rst_125p : clock, async active-high reset
//   i_enable      : link enable, low forces IDLE
//   i_iqdata_fp   : sample strobe;  i_rdempty : FIFO empty;  i_wrfull : FIFO full (RX domain, synchronised)
//   o_rx_if_rst_n : active-low RX interface/FIFO reset
//   o_link_up, o_data_valid, o_state, o_err_cnt, o_strobe_cnt : status
//   Macro AD80305_RX_LINK_STATS_EN enables the locked-strobe counter on o_strobe_cnt.
module ad80305_rx_link_ctrl
   import ad80305_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
   parameter int FP_PERIOD    = DEF_FP_PERIOD,
   parameter int LOCK_STROBES = DEF_LOCK_STROBES,
   parameter int ERR_CNT_W    = DEF_ERR_CNT_W
) (
   input  logic                 i_fpga_clk_125p,
   input  logic                 i_fpga_rst_125p,
   input  logic                 i_enable,
   input  logic                 i_iqdata_fp,
   input  logic                 i_rdempty,
   input  logic                 i_wrfull,
   output logic                 o_rx_if_rst_n,
   output logic                 o_link_up,
   output logic                 o_data_valid,
   output logic [2:0]           o_state,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output logic [31:0]          o_strobe_cnt
);
   localparam int RCW = $clog2(RST_CYCLES);
   localparam int FCW = $clog2(FILL_TIMEOUT);
   localparam int GCW = $clog2(LOCK_STROBES);
   state_t state, nxt;
   logic [RCW-1:0] rst_cnt;
   logic [FCW-1:0] fill_cnt;
   logic [GCW-1:0] good_cnt;
   logic wr_s1, wr_s2;
   logic fp_good, fp_err, fp_first;
   ad80305_fp_checker #(.FP_PERIOD(FP_PERIOD)) u_fp (
      .clk   (i_fpga_clk_125p),
      .rst   (i_fpga_rst_125p),
      .clr   (state != CHECK && state != LOCKED),
      .fp    (i_iqdata_fp),
      .good  (fp_good),
      .err   (fp_err),
      .first (fp_first)
   );
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = RESET;
         RESET:     nxt = rst_cnt == RCW'(RST_CYCLES - 1) ? WAIT_FILL : RESET;
         WAIT_FILL: nxt = !i_rdempty ? CHECK : fill_cnt == FCW'(FILL_TIMEOUT - 1) ? FAULT : WAIT_FILL;
         CHECK:     nxt = fp_err ? RESET : (fp_good && good_cnt == GCW'(LOCK_STROBES - 1)) ? LOCKED : CHECK;
         LOCKED:    nxt = (fp_err || wr_s2) ? FAULT : LOCKED;
         FAULT:     nxt = RESET;
         default:   nxt = IDLE;
      endcase
      if (!i_enable) nxt = IDLE;
   end
   always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p)
      if (i_fpga_rst_125p) begin
         state         <= IDLE;
         rst_cnt       <= '0;
         fill_cnt      <= '0;
         good_cnt      <= '0;
         wr_s1         <= 1'b0;
         wr_s2         <= 1'b0;
         o_err_cnt     <= '0;
         o_rx_if_rst_n <= 1'b0;
         o_link_up     <= 1'b0;
         o_data_valid  <= 1'b0;
      end else begin
         state         <= nxt;
         rst_cnt       <= state == RESET ? rst_cnt + RCW'(1) : '0;
         fill_cnt      <= state == WAIT_FILL ? fill_cnt + FCW'(1) : '0;
         good_cnt      <= (state != CHECK || fp_first || fp_err) ? '0 : good_cnt + GCW'(fp_good);
         wr_s1         <= i_wrfull;
         wr_s2         <= wr_s1;
         o_err_cnt     <= (state == FAULT && !(&o_err_cnt)) ? o_err_cnt + ERR_CNT_W'(1) : o_err_cnt;
         o_rx_if_rst_n <= nxt != IDLE && nxt != RESET;
         o_link_up     <= nxt == LOCKED;
         o_data_valid  <= state == LOCKED && i_iqdata_fp;
      end
   assign o_state = state;
`ifdef AD80305_RX_LINK_STATS_EN
   always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p)
      if (i_fpga_rst_125p) o_strobe_cnt <= '0;
      else if (state == RESET) o_strobe_cnt <= '0;
      else if (state == LOCKED && fp_good) o_strobe_cnt <= o_strobe_cnt + 32'd1;
`else
   assign o_strobe_cnt = '0;
`endif
endmodule

// File: tb/tb_ad80305_rx_link_ctrl.sv
// tb_ad80305_rx_link_ctrl: scoreboard bench for ad80305_rx_link_ctrl
module tb_ad80305_rx_link_ctrl;
   import ad80305_pkg::*;
   logic clk = 0, rst = 1, en = 1, fp = 0, rdempty = 1, wrfull = 0;
   logic rst_n, link_up, dvalid;
   logic [2:0] st;
   logic [7:0] ec;
   logic [31:0] scnt;
   int n_tests = 0, n_fail = 0;
   int fp_en = 0, drop_req = 0, drop_done = 0, early_req = 0, early_done = 0;
   int lockcnt = 0;
   typedef struct {logic [2:0] st; logic [7:0] ec; logic lu; logic rn;} exp_t;
   exp_t sb[$];

   ad80305_rx_link_ctrl #(.RST_CYCLES(16), .FILL_TIMEOUT(64), .FP_PERIOD(4), .LOCK_STROBES(32), .ERR_CNT_W(8)) dut (
      .i_fpga_clk_125p(clk), .i_fpga_rst_125p(rst), .i_enable(en), .i_iqdata_fp(fp),
      .i_rdempty(rdempty), .i_wrfull(wrfull), .o_rx_if_rst_n(rst_n), .o_link_up(link_up),
      .o_data_valid(dvalid), .o_state(st), .o_err_cnt(ec), .o_strobe_cnt(scnt));

   always #4 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0d req=%0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] s, input logic [7:0] e, input logic l, input logic r);
      exp_t x;
      x.st = s; x.ec = e; x.lu = l; x.rn = r;
      sb.push_back(x);
   endtask

   task automatic wait_empty(input string nm, input int budget);
      int i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout pending=%0d req=0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // strobe generator: one strobe every 4 clocks, with one-shot drop or early (gap 2) requests
   initial begin : gen
      int ph = 0;
      forever begin
         step();
         if (fp_en == 0) begin
            fp = 0;
            ph = 0;
         end else begin
            ph++;
            if (early_req != early_done && ph == 2) begin
               fp = 1; ph = 0; early_done++;
            end else if (ph == 4) begin
               fp = (drop_req == drop_done);
               if (drop_req != drop_done) drop_done++;
               ph = 0;
            end else fp = 0;
         end
      end
   end

   // monitor: pops an expectation on every state transition, tracks reset pulse width and locked strobes
   initial begin : mon
      logic [2:0] prev = 3'd0;
      int low = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (st != prev) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_transition act=%0d req=none", st);
            end else begin
               e = sb.pop_front();
               chk("trans_state", 32'(st), 32'(e.st));
               chk("trans_err_cnt", 32'(ec), 32'(e.ec));
               chk("trans_link_up", 32'(link_up), 32'(e.lu));
               if (e.st != 3'(FAULT)) chk("trans_rst_n", 32'(rst_n), 32'(e.rn));
            end
            if (prev == 3'(RESET) && st == 3'(WAIT_FILL)) chk("rst_n_low_cycles", 32'(low), 32'd16);
            low = 0;
         end
         if (st == 3'(RESET) && !rst_n) low++;
         if (st == 3'(RESET)) lockcnt = 0;
         else if (st == 3'(LOCKED) && fp) lockcnt++;
         prev = st;
      end
   end

   initial begin : main
      logic pfp;
      int n;
      #1;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(st), 32'd0);
      chk("rst_rst_n", 32'(rst_n), 32'd0);
      chk("rst_link_up", 32'(link_up), 32'd0);
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_err_cnt", 32'(ec), 32'd0);
      chk("rst_strobe_cnt", scnt, 32'd0);
      // bring-up with clean strobes
      push(RESET, 0, 0, 0); push(WAIT_FILL, 0, 0, 1); push(CHECK, 0, 0, 1); push(LOCKED, 0, 1, 1);
      step();
      rst = 0;
      fp_en = 1;
      repeat (5) step();
      rdempty = 0;
      wait_empty("bringup", 400);
      chk("lock_err_cnt", 32'(ec), 32'd0);
      @(negedge clk);
      pfp = fp;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("data_valid", 32'(dvalid), 32'(pfp));
         pfp = fp;
      end
      // dropped strobe in LOCKED
      push(FAULT, 0, 0, 1); push(RESET, 1, 0, 0); push(WAIT_FILL, 1, 0, 1); push(CHECK, 1, 0, 1); push(LOCKED, 1, 1, 1);
      step();
      drop_req++;
      wait_empty("drop", 600);
      chk("drop_err_cnt", 32'(ec), 32'd1);
      // wrfull for 3 clocks in LOCKED
      push(FAULT, 1, 0, 1); push(RESET, 2, 0, 0); push(WAIT_FILL, 2, 0, 1); push(CHECK, 2, 0, 1); push(LOCKED, 2, 1, 1);
      step();
      wrfull = 1;
      repeat (2) step();
      chk("wrfull_lat2_state", 32'(st), 32'(LOCKED));
      step();
      chk("wrfull_lat3_state", 32'(st), 32'(FAULT));
      wrfull = 0;
      wait_empty("wrfull", 600);
      // enable drop in LOCKED
      push(IDLE, 2, 0, 0);
      step();
      en = 0;
      step();
      chk("dis_state", 32'(st), 32'(IDLE));
      chk("dis_link_up", 32'(link_up), 32'd0);
      chk("dis_err_cnt", 32'(ec), 32'd2);
`ifdef AD80305_RX_LINK_STATS_EN
      chk("dis_strobe_cnt", scnt, 32'(lockcnt));
`else
      chk("dis_strobe_cnt", scnt, 32'd0);
`endif
      wait_empty("disable", 10);
      // early strobe during CHECK
      push(RESET, 2, 0, 0); push(WAIT_FILL, 2, 0, 1); push(CHECK, 2, 0, 1);
      en = 1;
      wait_empty("reenable", 100);
      repeat (10) step();
      push(RESET, 2, 0, 0); push(WAIT_FILL, 2, 0, 1); push(CHECK, 2, 0, 1); push(LOCKED, 2, 1, 1);
      early_req++;
      wait_empty("early", 600);
      chk("early_err_cnt", 32'(ec), 32'd2);
      // asynchronous reset mid-operation
      push(IDLE, 0, 0, 0);
      step();
      rst = 1;
      fp_en = 0;
      rdempty = 1;
      repeat (2) @(negedge clk);
      chk("midrst_err_cnt", 32'(ec), 32'd0);
      chk("midrst_link_up", 32'(link_up), 32'd0);
      chk("midrst_rst_n", 32'(rst_n), 32'd0);
      chk("midrst_strobe_cnt", scnt, 32'd0);
      wait_empty("midrst", 10);
      // fill timeout retries until the error counter saturates
      push(RESET, 0, 0, 0); push(WAIT_FILL, 0, 0, 1);
      for (int k = 1; k <= 256; k++) begin
         push(FAULT, 8'((k - 1) > 255 ? 255 : k - 1), 0, 1);
         push(RESET, 8'(k > 255 ? 255 : k), 0, 0);
         push(WAIT_FILL, 8'(k > 255 ? 255 : k), 0, 1);
      end
      step();
      rst = 0;
      n = 0;
      while (st != 3'(WAIT_FILL) && n < 100) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (st == 3'(WAIT_FILL) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("fill_timeout_cycles", 32'(n), 32'd64);
      chk("fill_timeout_state", 32'(st), 32'(FAULT));
      wait_empty("saturate", 25000);
      chk("sat_err_cnt", 32'(ec), 32'd255);
      push(IDLE, 255, 0, 0);
      step();
      en = 0;
      wait_empty("final_idle", 10);
      chk("final_err_cnt", 32'(ec), 32'd255);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
